// File: rtl/bp_resolve_update_pkg.sv
// ============================================================================
// Module  : bp_resolve_update_pkg
// Purpose : Shared widths and the in-flight branch record for the predictor
//           resolve/update path.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package bp_resolve_update_pkg;

    localparam int BP_ALIAS_W = 6;
    localparam int BP_DEPTH   = 8;

    // Metadata captured at fetch for one predicted branch (39 bits).
    typedef struct packed {
        logic [BP_ALIAS_W-1:0] br_alias;
        logic                  pred_taken;
        logic [31:0]           pred_target;
    } br_rec_t;

endpackage

`default_nettype wire

// File: rtl/bp_rec_fifo.sv
// ============================================================================
// Module  : bp_rec_fifo
// Purpose : Program-ordered circular buffer of branch records with flush.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module bp_rec_fifo
    import bp_resolve_update_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH,
    parameter int PTR_W = 3
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    flush,
    input  logic    enq_valid,
    input  br_rec_t enq_rec,
    input  logic    deq,
    output br_rec_t head,
    output logic    q_full,
    output logic    q_empty
);

    localparam logic [PTR_W:0] c_DEPTH = (PTR_W+1)'(DEPTH);

    br_rec_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_enq;
    logic w_deq;

    assign q_full  = (r_count == c_DEPTH);
    assign q_empty = (r_count == '0);

    // A flush discards the same-cycle enqueue: it belongs to the wrong path.
    assign w_enq = enq_valid && !q_full && !flush;
    assign w_deq = deq && !q_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{PTR_W{1'b0}}, w_enq} - {{PTR_W{1'b0}}, w_deq};
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wr_ptr] <= enq_rec;
    end

    assign head = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/bp_resolve_update.sv
// ============================================================================
// Module  : bp_resolve_update
// Purpose : Resolves the oldest in-flight branch against its prediction and
//           drives the predictor/BTB update bundle and mispredict redirect.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module bp_resolve_update
    import bp_resolve_update_pkg::*;
#(
    parameter int DEPTH   = BP_DEPTH,
    parameter int PTR_W   = 3,
    parameter int ALIAS_W = BP_ALIAS_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_valid,
    input  logic [ALIAS_W-1:0] enq_alias,
    input  logic               enq_pred_taken,
    input  logic [31:0]        enq_pred_target,
    output logic               q_full,
    output logic               q_empty,
    input  logic               res_valid,
    input  logic               res_taken,
    input  logic [31:0]        res_br_eip,
    input  logic [31:0]        res_target_eip,
    input  logic [31:0]        res_fip_e,
    input  logic [31:0]        res_fip_o,
    input  logic [31:0]        res_fallthru_eip,
    output logic               upd_LD,
    output logic               upd_BR_result,
    output logic [ALIAS_W-1:0] upd_BR_alias,
    output logic               upd_is_BR,
    output logic [31:0]        upd_btb_eip,
    output logic [31:0]        upd_FIP_E,
    output logic [31:0]        upd_FIP_O,
    output logic [31:0]        upd_EIP,
    output logic               mispredict,
    output logic [31:0]        redirect_eip,
    output logic               res_orphan
);

    br_rec_t     w_enq_rec;
    br_rec_t     w_head;
    logic        w_deq;
    logic        w_mp;
    logic [31:0] w_next;

    assign w_enq_rec = '{br_alias: enq_alias, pred_taken: enq_pred_taken,
                         pred_target: enq_pred_target};

    assign w_deq  = res_valid && !q_empty;
    assign w_mp   = (res_taken != w_head.pred_taken) ||
                    (res_taken && w_head.pred_taken && (res_target_eip != w_head.pred_target));
    assign w_next = res_taken ? res_target_eip : res_fallthru_eip;

    bp_rec_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (w_deq && w_mp),
        .enq_valid (enq_valid),
        .enq_rec   (w_enq_rec),
        .deq       (w_deq),
        .head      (w_head),
        .q_full    (q_full),
        .q_empty   (q_empty)
    );

    // Strobes pulse for one cycle; payload fields hold until the next resolve.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_LD        <= 1'b0;
            upd_is_BR     <= 1'b0;
            upd_BR_result <= 1'b0;
            upd_BR_alias  <= '0;
            upd_btb_eip   <= '0;
            upd_FIP_E     <= '0;
            upd_FIP_O     <= '0;
            upd_EIP       <= '0;
            mispredict    <= 1'b0;
            redirect_eip  <= '0;
            res_orphan    <= 1'b0;
        end else begin
            upd_LD     <= w_deq;
            upd_is_BR  <= w_deq;
            mispredict <= w_deq && w_mp;
            if (w_deq) begin
                upd_BR_result <= res_taken;
                upd_BR_alias  <= w_head.br_alias;
                upd_btb_eip   <= res_br_eip;
                upd_FIP_E     <= res_fip_e;
                upd_FIP_O     <= res_fip_o;
                upd_EIP       <= res_target_eip;
            end
            if (w_deq && w_mp) redirect_eip <= w_next;
            if (res_valid && q_empty) res_orphan <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: doc/bp_resolve_update.md
Name: bp_resolve_update

Overview:
- Branch-resolution and predictor-update controller; the write side of the fetch-stage predictor.
- Holds, in program order, the prediction metadata fetch issued for each branch: gshare alias, predicted direction, predicted target.
- When writeback resolves the oldest branch, it compares outcome against prediction. It then drives the one-cycle predictor/BTB update bundle and a mispredict redirect with queue flush.

Parameters:
- DEPTH, 8, number of in-flight branch records (power of two, ≥2)
- PTR_W, 3, log2(DEPTH)
- ALIAS_W, 6, gshare alias width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- enq_valid  in  1  fetch issued a predicted branch this cycle
- enq_alias  in  ALIAS_W  gshare alias used for the prediction
- enq_pred_taken  in  1  final fetch prediction (gshare AND btb_hit AND decode-valid)
- enq_pred_target  in  32  EIP fetch redirected to when predicted taken
- q_full  out  1  no free record; fetch must stall branch issue
- q_empty  out  1  no in-flight branch
- res_valid  in  1  WB resolves oldest in-flight branch
- res_taken  in  1  actual direction
- res_br_eip  in  32  EIP of the branch instruction
- res_target_eip  in  32  actual taken target EIP
- res_fip_e  in  32  even fetch line address of target
- res_fip_o  in  32  odd fetch line address of target
- res_fallthru_eip  in  32  EIP of next sequential instruction
- upd_LD  out  1  predictor update strobe
- upd_BR_result  out  1  resolved direction for gshare/BTB
- upd_BR_alias  out  ALIAS_W  alias to update
- upd_is_BR  out  1  update refers to a branch
- upd_btb_eip  out  32  BTB index EIP
- upd_FIP_E  out  32  BTB even-line payload
- upd_FIP_O  out  32  BTB odd-line payload
- upd_EIP  out  32  BTB target EIP payload
- mispredict  out  1  one-cycle flush/redirect pulse
- redirect_eip  out  32  correct next EIP
- res_orphan  out  1  sticky error: resolution with empty queue

Behaviour:
- Reset (async, immediate):
  - rd_ptr, wr_ptr and count are 0; q_empty=1, q_full=0.
  - All upd_* and mispredict outputs are 0; redirect_eip=0; res_orphan=0.
  - Record storage contents are don't-care.
- Queue:
  - Circular buffer; pointers wrap DEPTH-1→0. count is PTR_W+1 bits.
  - q_full=(count==DEPTH) and q_empty=(count==0), both combinational from count.
  - Enqueue is accepted when enq_valid && !q_full. enq_valid while full is ignored; it is a fetch protocol violation, not an error output.
  - Dequeue occurs when res_valid && !q_empty.
  - Simultaneous accepted enq and non-mispredict deq: count is unchanged; both pointers advance. This is allowed at full only if deq happens; q_full still blocks the enq that cycle.
- Resolution compare (combinational on head record):
  - mp = (res_taken != head.pred_taken) || (res_taken && head.pred_taken && res_target_eip != head.pred_target).
  - next = res_taken ? res_target_eip : res_fallthru_eip.
- Update outputs, registered, latency 1:
  - On the edge after a dequeue, upd_LD=upd_is_BR=1.
  - upd_BR_result=res_taken and upd_BR_alias=head.alias.
  - upd_btb_eip=res_br_eip; upd_FIP_E/O and upd_EIP are taken from res_fip_e/o and res_target_eip.
  - All of these hold for exactly one cycle; the strobes return to 0 otherwise. The data fields hold their last value.
- Mispredict:
  - mispredict=1 and redirect_eip=next are registered with the same latency.
  - On that same edge the queue flushes: rd_ptr=wr_ptr=0 and count=0.
  - An enqueue presented in the mispredicting cycle is dropped, because it is wrong-path.
  - The cycle after the pulse, the queue is empty and accepts enqueues normally.
- Orphan:
  - res_valid while q_empty sets res_orphan (sticky until reset).
  - No update pulse is produced.
- Back-to-back resolutions in consecutive cycles produce consecutive update pulses; there are no bubbles.

Decomposition:
- Shared package: ALIAS_W, the DEPTH default, and a branch-record struct {alias, pred_taken, pred_target} (39 bits).
- Sub-module: bp_rec_fifo, the DEPTH-entry record FIFO with pointers, count, flush input and full/empty outputs. Compare and update registers stay in the top.

Test Plan:
- Correct not-taken: enq(alias=0x15, pred=0, tgt=0), then res(taken=0, br_eip=0x1000, fallthru=0x1002) → next cycle upd_LD=1, upd_BR_result=0, upd_BR_alias=0x15, mispredict=0, q_empty=1.
- Direction mispredict with flush: enq three records (first pred=0), then res(taken=1, target=0x2040) → mispredict=1, redirect_eip=0x2040, upd_BR_result=1; count=0 next cycle; a same-cycle enq is dropped.
- Target mispredict: enq(pred=1, tgt=0x3000), then res(taken=1, target=0x3010, fip_e=0x3000, fip_o=0x3010) → mispredict=1, redirect_eip=0x3010, upd_FIP_O=0x3010, upd_EIP=0x3010.
- Full and wrap: 8 enqs → q_full=1 and a 9th enq is ignored. Then resolve all 8 correctly, back-to-back, while re-enqueueing → 8 consecutive upd_LD pulses whose aliases match insertion order across the pointer wrap.
- Orphan and async reset: res_valid with empty queue → res_orphan=1, no upd_LD. Asserting reset mid-cycle with 3 records queued → all outputs 0 and q_empty=1 immediately, without waiting for clk.
